// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C EEPROM responder and the i2c_top reader:
// FSM state encoding, ACK/NACK bus levels, EEPROM page geometry and the
// page-wrapping pointer increment used by page writes.
// -----------------------------------------------------------------------------
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ADR,
    ST_DEV_ACK,
    ST_WORD_ADR,
    ST_WORD_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK
  } i2c_state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam int EEPROM_PAGE_SIZE = 8;
  localparam int EEPROM_PAGE_BITS = $clog2(EEPROM_PAGE_SIZE);

  // Advance the byte pointer within its page: low bits wrap, page bits hold.
  function automatic logic [7:0] page_inc(input logic [7:0] ptr);
    logic [EEPROM_PAGE_BITS-1:0] low;
    low = ptr[EEPROM_PAGE_BITS-1:0] + EEPROM_PAGE_BITS'(1);
    return {ptr[7:EEPROM_PAGE_BITS], low};
  endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// -----------------------------------------------------------------------------
// i2c_line_filter
// Conditions one asynchronous open-drain line (SCL or SDA): a 2-FF
// synchroniser followed by a stability filter that accepts a new level only
// after FILT_CYC consecutive equal samples. Pad-to-level latency is
// 2 + FILT_CYC clk cycles; rise/fall strobe in the cycle the level changes.
//   clk, rst_n : system clock, async active-low reset (line idles high)
//   raw        : pad level
//   level      : filtered level
//   rise, fall : one-cycle strobes on accepted transitions
// -----------------------------------------------------------------------------
module i2c_line_filter #(
  parameter int FILT_CYC = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(FILT_CYC + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // NOTE: every register here is updated with <= so all flops sample the
  // pre-edge values; blocking assignments would chain the synchroniser
  // stages into a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILT_CYC - 1)) begin
        cnt   <= '0;
        level <= sync[1];
        rise  <= sync[1];
        fall  <= ~sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_eeprom_responder.sv
// -----------------------------------------------------------------------------
// i2c_eeprom_responder
// I2C target emulating a 24xx02-style 256-byte EEPROM. Supports byte/page
// write (8-byte page wrap), random, current-address and sequential read.
// A fabric port preloads and reads back the array.
//   clk, reset_n          : 125 MHz clock, async active-low reset
//   scl_pad_i, sda_pad_i  : bus levels (asynchronous)
//   sda_pad_o             : constant 0 (open-drain)
//   sda_padoen_o          : 0 pulls SDA low, 1 releases it
//   mem_we/adr/wdat       : fabric write port
//   mem_rdat              : fabric read data, registered, 1 cycle after mem_adr
//   busy                  : address-matched transfer in progress
//   wr_done               : one-cycle pulse per byte stored from I2C
// -----------------------------------------------------------------------------
module i2c_eeprom_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADR  = 7'b1010_000,
  parameter int         FILT_CYC = 3,
  parameter int         HOLD_CYC = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl_pad_i,
  input  logic       sda_pad_i,
  output logic       sda_pad_o,
  output logic       sda_padoen_o,
  input  logic       mem_we,
  input  logic [7:0] mem_adr,
  input  logic [7:0] mem_wdat,
  output logic [7:0] mem_rdat,
  output logic       busy,
  output logic       wr_done
);

  localparam int HW = $clog2(HOLD_CYC + 1);

  logic scl_f, scl_rise, scl_fall;
  logic sda_f, sda_rise, sda_fall;

  i2c_line_filter #(.FILT_CYC(FILT_CYC)) u_scl_filt (
    .clk(clk), .rst_n(reset_n), .raw(scl_pad_i),
    .level(scl_f), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_line_filter #(.FILT_CYC(FILT_CYC)) u_sda_filt (
    .clk(clk), .rst_n(reset_n), .raw(sda_pad_i),
    .level(sda_f), .rise(sda_rise), .fall(sda_fall)
  );

  i2c_state_t    state;
  logic [3:0]    bit_cnt;
  logic [6:0]    rx_sh;
  logic [6:0]    tx_sh;
  logic [7:0]    ptr;
  logic          rd_req;
  logic [HW-1:0] hold_cnt;
  logic          oe_pend;
  logic [7:0]    i2c_rdat;

  logic       start_cond, stop_cond, byte_done, i2c_we, counting;
  logic [7:0] rx_next;

  assign sda_pad_o  = 1'b0;
  assign start_cond = sda_fall & scl_f;
  assign stop_cond  = sda_rise & scl_f;
  assign rx_next    = {rx_sh, sda_f};
  assign byte_done  = scl_rise && (bit_cnt == 4'd7);
  assign counting   = (state == ST_DEV_ADR) || (state == ST_WORD_ADR) ||
                      (state == ST_WR_DATA) || (state == ST_RD_DATA);
  assign i2c_we     = (state == ST_WR_DATA) && byte_done && !start_cond && !stop_cond;

  // Bus FSM. Every SDA change is scheduled on an SCL fall and applied
  // HOLD_CYC cycles later through hold_cnt/oe_pend; START/STOP cancel any
  // pending change and release SDA at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      rx_sh        <= '0;
      tx_sh        <= '0;
      ptr          <= '0;
      rd_req       <= 1'b0;
      hold_cnt     <= '0;
      oe_pend      <= 1'b1;
      sda_padoen_o <= 1'b1;
      busy         <= 1'b0;
      wr_done      <= 1'b0;
    end else begin
      wr_done <= i2c_we;
      if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 1'b1;
        if (hold_cnt == HW'(1)) sda_padoen_o <= oe_pend;
      end

      if (start_cond) begin
        state        <= ST_DEV_ADR;
        bit_cnt      <= '0;
        hold_cnt     <= '0;
        sda_padoen_o <= 1'b1;
      end else if (stop_cond) begin
        state        <= ST_IDLE;
        bit_cnt      <= '0;
        hold_cnt     <= '0;
        sda_padoen_o <= 1'b1;
        busy         <= 1'b0;
      end else begin
        if (scl_rise && counting && bit_cnt != 4'd8) begin
          rx_sh   <= rx_next[6:0];
          bit_cnt <= bit_cnt + 1'b1;
        end

        unique case (state)
          ST_IDLE: ;
          ST_DEV_ADR: begin
            if (byte_done) begin
              if (rx_next[7:1] == DEV_ADR) begin
                rd_req <= rx_next[0];
                busy   <= 1'b1;
              end else begin
                state   <= ST_IDLE;
                bit_cnt <= '0;
                busy    <= 1'b0;
              end
            end else if (scl_fall && bit_cnt == 4'd8) begin
              state    <= ST_DEV_ACK;
              bit_cnt  <= '0;
              hold_cnt <= HW'(HOLD_CYC);
              oe_pend  <= I2C_ACK;
            end
          end
          ST_DEV_ACK: begin
            if (scl_fall) begin
              hold_cnt <= HW'(HOLD_CYC);
              if (rd_req) begin
                // First read bit goes out on this fall, so load from the
                // continuously refreshed pointer read.
                state   <= ST_RD_DATA;
                tx_sh   <= i2c_rdat[6:0];
                oe_pend <= i2c_rdat[7];
              end else begin
                state   <= ST_WORD_ADR;
                oe_pend <= 1'b1;
              end
            end
          end
          ST_WORD_ADR, ST_WR_DATA: begin
            if (byte_done) begin
              ptr <= (state == ST_WORD_ADR) ? rx_next : page_inc(ptr);
            end else if (scl_fall && bit_cnt == 4'd8) begin
              state    <= (state == ST_WORD_ADR) ? ST_WORD_ACK : ST_WR_ACK;
              bit_cnt  <= '0;
              hold_cnt <= HW'(HOLD_CYC);
              oe_pend  <= I2C_ACK;
            end
          end
          ST_WORD_ACK, ST_WR_ACK: begin
            if (scl_fall) begin
              state    <= ST_WR_DATA;
              hold_cnt <= HW'(HOLD_CYC);
              oe_pend  <= 1'b1;
            end
          end
          ST_RD_DATA: begin
            if (scl_fall && bit_cnt == 4'd8) begin
              state    <= ST_RD_ACK;
              bit_cnt  <= '0;
              ptr      <= ptr + 1'b1;
              hold_cnt <= HW'(HOLD_CYC);
              oe_pend  <= 1'b1;
            end else if (scl_fall && bit_cnt != 4'd0) begin
              tx_sh    <= {tx_sh[5:0], 1'b1};
              hold_cnt <= HW'(HOLD_CYC);
              oe_pend  <= tx_sh[6];
            end
          end
          ST_RD_ACK: begin
            if (scl_rise && sda_f == I2C_NACK) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else if (scl_fall) begin
              state    <= ST_RD_DATA;
              tx_sh    <= i2c_rdat[6:0];
              hold_cnt <= HW'(HOLD_CYC);
              oe_pend  <= i2c_rdat[7];
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // NOTE: the array has no reset branch so it maps onto block RAM; its
  // power-up content comes from the declaration initialiser instead.
  logic [7:0] mem [256] = '{default: 8'hFF};

  // I2C port wins a same-address collision; fabric write is dropped.
  always_ff @(posedge clk) begin
    if (i2c_we) mem[ptr] <= rx_next;
    if (mem_we && !(i2c_we && mem_adr == ptr)) mem[mem_adr] <= mem_wdat;
    i2c_rdat <= mem[ptr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mem_rdat <= '0;
    else          mem_rdat <= mem[mem_adr];
  end

endmodule
